// File: rtl/fifo_pkg.sv
// Shared definitions for the fifo_gen slice: default widths and depth derivation.
package fifo_pkg;

   localparam int unsigned DEF_DATA_WIDTH = 6;
   localparam int unsigned DEF_ADDR_WIDTH = 3;

   // Number of storage words addressed by an aw-bit pointer.
   function automatic int unsigned fifo_depth(input int unsigned aw);
      return 32'(1) << aw;
   endfunction

endpackage : fifo_pkg

// File: rtl/fifo_mem.sv
// Storage for fifo_gen: DEPTH x DATA_WIDTH array, one synchronous write port
// and one synchronous read port whose output register holds between reads.
// Ports:
//   clk, reset_L        - clock, synchronous active-low reset (read register only)
//   i_wr_en/addr/data   - write port
//   i_rd_en/addr        - read port request
//   o_rd_data           - registered read data
module fifo_mem
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset_L,
   input  logic                  i_wr_en,
   input  logic [ADDR_WIDTH-1:0] i_wr_addr,
   input  logic [DATA_WIDTH-1:0] i_wr_data,
   input  logic                  i_rd_en,
   input  logic [ADDR_WIDTH-1:0] i_rd_addr,
   output logic [DATA_WIDTH-1:0] o_rd_data
);

   localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   // Array is never cleared; reset only discards it logically via pointers.
   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   // Same-address read/write returns the old word (needed when full with read+write).
   always_ff @(posedge clk) begin
      if (!reset_L) begin
         o_rd_data <= '0;
      end else if (i_rd_en) begin
         o_rd_data <= r_mem[i_rd_addr];
      end
   end

endmodule : fifo_mem

// File: rtl/fifo_gen.sv
// Synchronous FIFO with live almost-full/almost-empty thresholds.
// Optional macro FIFO_ERR_FLAGS_EN enables sticky overflow/underflow flags;
// without it those ports are tied to 0.
// Ports:
//   clk, reset_L                      - clock, synchronous active-low reset
//   write, read, buff_in              - push/pop requests and push data
//   umb_almost_full, umb_almost_empty - status thresholds
//   buff_out, valid_out               - pop data (1-cycle latency) and its strobe
//   data_count                        - stored words, 0..DEPTH
//   fifo_full, fifo_empty, almost_*   - status decoded from the registered count
//   overflow, underflow               - sticky error flags
module fifo_gen
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset_L,
   input  logic                  write,
   input  logic                  read,
   input  logic [DATA_WIDTH-1:0] buff_in,
   input  logic [ADDR_WIDTH:0]   umb_almost_full,
   input  logic [ADDR_WIDTH:0]   umb_almost_empty,
   output logic [DATA_WIDTH-1:0] buff_out,
   output logic                  valid_out,
   output logic [ADDR_WIDTH:0]   data_count,
   output logic                  fifo_full,
   output logic                  fifo_empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);
   localparam int unsigned CW    = ADDR_WIDTH + 1;

   logic [ADDR_WIDTH-1:0] r_wr_ptr;
   logic [ADDR_WIDTH-1:0] r_rd_ptr;
   logic [CW-1:0]         r_count;
   logic                  r_valid;
   logic                  w_wr_ok;
   logic                  w_rd_ok;

   // A full FIFO still accepts a write when a read frees a slot in the same cycle.
   assign w_wr_ok = write && (!fifo_full || read);
   assign w_rd_ok = read && !fifo_empty;

   // Pointer, count and read-strobe state.
   always_ff @(posedge clk) begin
      if (!reset_L) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_valid  <= 1'b0;
      end else begin
         r_valid <= w_rd_ok;
         if (w_wr_ok) begin
            r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
         end
         if (w_rd_ok) begin
            r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
         end
         case ({w_wr_ok, w_rd_ok})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_mem (
      .clk       (clk),
      .reset_L   (reset_L),
      .i_wr_en   (w_wr_ok),
      .i_wr_addr (r_wr_ptr),
      .i_wr_data (buff_in),
      .i_rd_en   (w_rd_ok),
      .i_rd_addr (r_rd_ptr),
      .o_rd_data (buff_out)
   );

   // Status flags depend only on the registered count and the threshold inputs.
   assign data_count   = r_count;
   assign valid_out    = r_valid;
   assign fifo_empty   = (r_count == '0);
   assign fifo_full    = (r_count == CW'(DEPTH));
   assign almost_full  = (r_count >= umb_almost_full);
   assign almost_empty = (r_count <= umb_almost_empty);

`ifdef FIFO_ERR_FLAGS_EN
   logic r_overflow;
   logic r_underflow;

   // Sticky error flags, cleared only by reset.
   always_ff @(posedge clk) begin
      if (!reset_L) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (write && !w_wr_ok) begin
            r_overflow <= 1'b1;
         end
         if (read && fifo_empty) begin
            r_underflow <= 1'b1;
         end
      end
   end

   assign overflow  = r_overflow;
   assign underflow = r_underflow;
`else
   assign overflow  = 1'b0;
   assign underflow = 1'b0;
`endif

endmodule : fifo_gen

// File: doc/fifo_gen.md
FIFO_GEN -- requirements
Module: fifo_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 6: bits per stored word.
REQ-002 SHALL have parameter ADDR_WIDTH, default 3: pointer width, with DEPTH = 2**ADDR_WIDTH (default 8).
REQ-003 SHALL have port clk  in  1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_L  in  1: reset, synchronous and active-low.
REQ-005 SHALL have port write  in  1: push request.
REQ-006 SHALL have port read  in  1: pop request.
REQ-007 SHALL have port buff_in  in  DATA_WIDTH: push data.
REQ-008 SHALL have port umb_almost_full  in  ADDR_WIDTH+1: almost-full threshold.
REQ-009 SHALL have port umb_almost_empty  in  ADDR_WIDTH+1: almost-empty threshold.
REQ-010 SHALL have port buff_out  out  DATA_WIDTH: registered pop data.
REQ-011 SHALL have port valid_out  out  1: buff_out updated this cycle.
REQ-012 SHALL have port data_count  out  ADDR_WIDTH+1: stored words, 0..DEPTH.
REQ-013 SHALL have ports fifo_full, fifo_empty, almost_full, almost_empty  out  1 each: status flags.
REQ-014 SHALL have ports overflow, underflow  out  1 each: sticky error flags.

Function
REQ-015 SHALL accept a write (wr_ok) iff write=1 and (fifo_full=0 or read=1).
REQ-016 SHALL accept a read (rd_ok) iff read=1 and fifo_empty=0; reads of an empty FIFO are ignored, even with a same-cycle write.
REQ-017 SHALL store buff_in at wr_ptr on wr_ok; wr_ptr increments modulo DEPTH.
REQ-018 SHALL on rd_ok load the word at rd_ptr into buff_out at the same edge and assert valid_out for exactly that following cycle; rd_ptr increments modulo DEPTH. Read latency 1 cycle.
REQ-019 SHALL hold buff_out unchanged when no read is accepted; valid_out=0.
REQ-020 SHALL update data_count at each edge by +1 (wr_ok only), -1 (rd_ok only), or 0 (both or neither).
REQ-021 SHALL, when full with read=write=1, accept both, keep data_count=DEPTH, and preserve FIFO order.
REQ-022 SHALL decode fifo_empty = (data_count==0) and fifo_full = (data_count==DEPTH) from the registered count.
REQ-023 SHALL decode almost_full = (data_count >= umb_almost_full) and almost_empty = (data_count <= umb_almost_empty), unsigned compare, thresholds live (not latched).
REQ-024 SHALL be glitch-free on status flags: all flags derive from registered state only, not from read/write.

Reset
REQ-025 SHALL, at a rising edge with reset_L=0, clear wr_ptr, rd_ptr, data_count, buff_out, valid_out, overflow and underflow to 0, regardless of read/write.
REQ-026 SHALL therefore show fifo_empty=1, fifo_full=0 after reset, with almost_empty=1 and almost_full=(umb_almost_full==0).
REQ-027 SHALL discard all contents on reset mid-operation; storage array contents are not cleared.

Configuration
REQ-028 SHALL, with FIFO_ERR_FLAGS_EN defined, set overflow when write=1 and wr_ok=0, and set underflow when read=1 and fifo_empty=1; both are sticky until reset.
REQ-029 SHALL, without FIFO_ERR_FLAGS_EN, keep overflow and underflow ports present and tied to 0, with no error logic.

Structure
REQ-030 SHALL place the default widths and the DEPTH derivation function in the shared package fifo_pkg.
REQ-031 SHALL implement storage as one sub-module fifo_mem: DEPTH x DATA_WIDTH, one synchronous write port and one synchronous read port. Pointer, count and flag logic stays in fifo_gen.

Verification (DATA_WIDTH=6, ADDR_WIDTH=3, umb_almost_full=6, umb_almost_empty=3)
REQ-032 SHALL cover fill: reset, then 8 writes of 0x03..0x0A -> data_count 1..8, almost_empty drops at count 4, almost_full rises at count 6, fifo_full=1 at count 8.
REQ-033 SHALL cover overflow: 3 further writes while full, no read -> data_count stays 8, contents unchanged, overflow=1 (0 if macro undefined).
REQ-034 SHALL cover drain: 10 consecutive reads -> buff_out 0x03..0x0A, each 1 cycle after its read, valid_out high 8 cycles; fifo_empty=1 after 8 reads; underflow=1 from the 9th read.
REQ-035 SHALL cover simultaneous access: full, with read=write=1 and buff_in=0x3F -> buff_out=0x03, data_count=8, and 0x3F appears as the 8th subsequent pop. Empty, with read=write=1 -> valid_out=0, data_count=1.
REQ-036 SHALL cover wrap and reset: 20 interleaved push/pop with count 2..5 -> pointers wrap, order preserved. Then reset_L=0 for 1 cycle at count 5 -> data_count=0, fifo_empty=1, overflow=underflow=0.
